// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// The frame header byte, the padding word and the FSM states live here.
package loader_pkg;

    localparam logic [7:0]  FRAME_HDR = 8'hA5;
    localparam logic [15:0] NOP_WORD  = 16'h0000;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        HDR  = 4'd1,
        CNT  = 4'd2,
        HI   = 4'd3,
        LO   = 4'd4,
        CSUM = 4'd5,
        FILL = 4'd6,
        DONE = 4'd7,
        ERR  = 4'd8
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
// The master modport is the loader's view; the slave modport is the environment's.
interface imem_loader_if #(
    parameter int ADDR_W = 4
);

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

endinterface

// File: rtl/imem_loader.sv
// Receives a framed byte stream, writes 16-bit instruction words into the
// instruction memory, pads the rest with NOPs and holds the CPU until success.
module imem_loader
    import loader_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err
);

    // Index and count are one bit wider than an address so that DEPTH fits.
    localparam logic [ADDR_W:0] ONE_W    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [7:0]      DEPTH_B  = 8'(DEPTH);

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        hi_q, hi_d;

    logic              xfer;
    logic [7:0]        rx;
    logic [ADDR_W:0]   idx_inc;

    assign xfer    = bus.in_valid && in_ready_q;
    assign rx      = bus.in_data;
    assign idx_inc = idx_q + ONE_W;

    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        hi_d      = hi_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = HDR;
                    idx_d   = '0;
                    csum_d  = '0;
                end
            end
            HDR: begin
                if (xfer && rx == FRAME_HDR) begin
                    state_d = CNT;
                end
            end
            CNT: begin
                if (xfer) begin
                    if (rx == 8'd0 || rx > DEPTH_B) begin
                        state_d = ERR;
                    end else begin
                        cnt_d   = rx[ADDR_W:0];
                        state_d = HI;
                    end
                end
            end
            HI: begin
                if (xfer) begin
                    hi_d    = rx;
                    csum_d  = csum_q ^ rx;
                    state_d = LO;
                end
            end
            LO: begin
                if (xfer) begin
                    csum_d    = csum_q ^ rx;
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q[ADDR_W-1:0];
                    wr_data_d = {hi_q, rx};
                    idx_d     = idx_inc;
                    state_d   = (idx_inc < cnt_q) ? HI : CSUM;
                end
            end
            CSUM: begin
                if (xfer) begin
                    if (rx != csum_q) begin
                        state_d = ERR;
                    end else if (cnt_q < DEPTH_W) begin
                        state_d = FILL;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FILL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = idx_q[ADDR_W-1:0];
                wr_data_d = NOP_WORD;
                idx_d     = idx_inc;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered as a function of the state being entered.
        in_ready_d = (state_d == HDR) || (state_d == CNT) || (state_d == HI) ||
                     (state_d == LO)  || (state_d == CSUM);
        busy_d     = !((state_d == IDLE) || (state_d == DONE) || (state_d == ERR));
        done_d     = (state_d == DONE);
        err_d      = (state_d == ERR);
        cpu_hold_d = (state_d != DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            cnt_q      <= '0;
            csum_q     <= '0;
            hi_q       <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_hold_q <= cpu_hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            csum_q     <= csum_d;
            hi_q       <= hi_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign cpu_hold     = cpu_hold_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames with hand-computed words and checksums,
// a write monitor on the memory port, and final status checks per scenario.
module tb_imem_loader;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic cpu_hold, busy, done, err;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus();

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus.master),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;
    int cycle = 0;

    int wrAddrQ[$];
    int wrDataQ[$];
    int wrCycQ[$];

    logic [7:0]  frameQ[$];
    logic [15:0] expWords[DEPTH];

    always @(posedge clk) cycle <= cycle + 1;

    // Every write strobe seen on the memory port is logged with its cycle.
    always @(negedge clk) begin
        if (bus.wr_en) begin
            wrAddrQ.push_back(int'(bus.wr_addr));
            wrDataQ.push_back(int'(bus.wr_data));
            wrCycQ.push_back(cycle);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic startPulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        int tries = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        if (!bus.in_ready) checkOutput("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Clears the write log, pulses start, then streams nBytes of frameQ.
    task automatic applyStimulus(input int gap, input int nBytes, input int extraStartAt);
        wrAddrQ.delete();
        wrDataQ.delete();
        wrCycQ.delete();
        startPulse();
        for (int i = 0; i < nBytes; i++) begin
            if (i == extraStartAt) startPulse();
            sendByte(frameQ[i]);
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic checkWrites(input string tag, input int nWords, input bit fill);
        int expCount = fill ? DEPTH : nWords;
        int n;
        checkOutput({tag, "_nwrites"}, 32'(wrAddrQ.size()), 32'(expCount));
        n = (wrAddrQ.size() < expCount) ? wrAddrQ.size() : expCount;
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), 32'(wrAddrQ[i]), 32'(i));
            checkOutput($sformatf("%s_data%0d", tag, i), 32'(wrDataQ[i]),
                        (i < nWords) ? 32'(expWords[i]) : 32'd0);
        end
        if (fill && wrCycQ.size() == DEPTH)
            checkOutput({tag, "_fillspan"}, 32'(wrCycQ[DEPTH-1] - wrCycQ[nWords]),
                        32'(DEPTH - 1 - nWords));
    endtask

    task automatic checkFinal(input string tag, input bit expDone, input bit expErr);
        checkOutput({tag, "_done"}, 32'(done), 32'(expDone));
        checkOutput({tag, "_err"}, 32'(err), 32'(expErr));
        checkOutput({tag, "_hold"}, 32'(cpu_hold), 32'(!expDone));
        checkOutput({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
        checkOutput({tag, "_wren"}, 32'(bus.wr_en), 32'd0);
        checkOutput({tag, "_addr"}, 32'(bus.wr_addr), 32'd0);
        checkOutput({tag, "_data"}, 32'(bus.wr_data), 32'd0);
        checkOutput({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic loadFrameOne();
        frameQ = '{8'hA5, 8'h04, 8'h11, 8'h05, 8'h12, 8'h0A,
                   8'h23, 8'h12, 8'h34, 8'h31, 8'h38};
        expWords[0] = 16'h1105;
        expWords[1] = 16'h120A;
        expWords[2] = 16'h2312;
        expWords[3] = 16'h3431;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        for (int i = 0; i < DEPTH; i++) expWords[i] = 16'h0000;
        repeat (2) @(negedge clk);
        checkResetValues("por");
        reset = 1'b1;
        @(negedge clk);

        loadFrameOne();
        applyStimulus(0, 11, -1);
        waitIdle("s1");
        checkWrites("s1", 4, 1'b1);
        checkFinal("s1", 1'b1, 1'b0);

        frameQ[10] = 8'h39;
        applyStimulus(0, 11, -1);
        waitIdle("s2");
        checkWrites("s2", 4, 1'b0);
        checkFinal("s2", 1'b0, 1'b1);

        frameQ = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h11, 8'h05, 8'h14};
        expWords[0] = 16'h1105;
        applyStimulus(0, 8, -1);
        waitIdle("s3");
        checkWrites("s3", 1, 1'b1);
        checkFinal("s3", 1'b1, 1'b0);

        frameQ = '{8'hA5, 8'h11};
        applyStimulus(0, 2, -1);
        waitIdle("s4a");
        checkWrites("s4a", 0, 1'b0);
        checkFinal("s4a", 1'b0, 1'b1);

        frameQ = '{8'hA5, 8'h00};
        applyStimulus(0, 2, -1);
        waitIdle("s4b");
        checkWrites("s4b", 0, 1'b0);
        checkFinal("s4b", 1'b0, 1'b1);

        loadFrameOne();
        applyStimulus(3, 11, -1);
        waitIdle("s5");
        checkWrites("s5", 4, 1'b1);
        checkFinal("s5", 1'b1, 1'b0);

        applyStimulus(0, 6, -1);
        #2 reset = 1'b0;
        #1 checkResetValues("s6rst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(0, 11, 3);
        waitIdle("s6");
        checkWrites("s6", 4, 1'b1);
        checkFinal("s6", 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the CPU instruction memory. It accepts a framed byte stream over a valid/ready handshake and assembles 16-bit instruction words (opcode[15:12], rd[11:8], rs[7:4], rt/imm). It writes those words into the instruction memory write port, pads unused slots with NOP (16'h0000) and holds the CPU in reset until a frame loads cleanly.

Parameters:
DEPTH, 16, number of instruction-memory words
ADDR_W, 4, instruction-memory address width (clog2 of DEPTH)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  one-cycle pulse that begins a load; ignored while busy=1
in_valid  input  1  byte available on in_data
in_data  input  8  stream byte
in_ready  output  1  loader can accept a byte; a byte transfers on a clk edge with in_valid&in_ready
wr_en  output  1  one-cycle instruction-memory write strobe
wr_addr  output  ADDR_W  write address
wr_data  output  16  instruction word
cpu_hold  output  1  level; 1 keeps the CPU in reset
busy  output  1  load in progress (every state except IDLE, DONE and ERR)
done  output  1  level; last load succeeded
err  output  1  level; last load failed

Behaviour:
- Reset (asynchronous, reset=0) forces: state IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, busy=0, done=0, err=0, word index=0, checksum=0. Reset mid-load abandons the frame immediately.
- Frame format: header 8'hA5, count N, then 2N payload bytes with each word sent high byte first, then a checksum byte. The checksum is the XOR of all 2N payload bytes, starting from 8'h00.
- States: IDLE, HDR, CNT, HI, LO, CSUM, FILL, DONE, ERR.
- IDLE/DONE/ERR + start: go to HDR; clear done, err, index and checksum; set cpu_hold=1.
- HDR: in_ready=1. A byte other than A5 is discarded and the state stays HDR (resync). A5 goes to CNT.
- CNT: in_ready=1. N=0 or N>DEPTH goes to ERR. Otherwise latch N and go to HI.
- HI: in_ready=1. Latch the high byte, fold it into the checksum, go to LO.
- LO: in_ready=1. On the accepted byte, the next edge drives wr_en=1, wr_addr=index and wr_data={hi,lo}, then index increments. Go to HI if index+1<N, else CSUM.
- wr_en is high for exactly one cycle per word. Write latency is 1 cycle after the LO byte is accepted.
- CSUM: in_ready=1. A mismatch goes to ERR. A match goes to FILL if N<DEPTH, else DONE.
- FILL: in_ready=0. Writes 16'h0000 to addresses N..DEPTH-1, one per cycle on consecutive cycles, then goes to DONE.
- DONE: done=1, cpu_hold=0. Held until the next start.
- ERR: err=1, cpu_hold=1, no FILL writes. Partially written words stay in memory but never execute.
- in_ready is a registered function of state. It is 0 in IDLE, FILL, DONE and ERR.
- Gaps in in_valid are legal at any point. The state only advances on a transfer.
- start while busy=1 is ignored. in_valid while in_ready=0 is ignored, with no side effects.
- wr_addr never exceeds DEPTH-1. The index counter is ADDR_W+1 bits wide so that index==DEPTH is detectable.

Decomposition:
- Shared package loader_pkg: FRAME_HDR=8'hA5, NOP_WORD=16'h0000, and the state encoding (localparams for the 9 states).
- Single module. No sub-module is warranted; checksum and index logic stay inline.

Test Plan:
1. start; bytes A5 04 11 05 12 0A 23 12 34 31 38 -> writes addr0=1105, addr1=120A, addr2=2312, addr3=3431, then 12 FILL writes of 0000 to addr4..15 on consecutive cycles; then done=1, cpu_hold=0, err=0.
2. Same frame with checksum 39 -> 4 writes then err=1, cpu_hold=1, done=0; no writes to addr4..15.
3. start; bytes 00 FF 5A A5 01 11 05 14 -> the first three bytes are discarded; addr0=1105 is written, then FILL addr1..15; done=1.
4. start; A5 11 (N=17 > DEPTH) -> ERR right after the count byte, err=1, no wr_en; A5 00 -> same result.
5. Scenario 1 with in_valid deasserted for 3 cycles between every byte -> write sequence and final state identical to scenario 1.
6. Assert reset=0 after the 6th byte of scenario 1 -> all outputs return to reset values asynchronously; release reset, rerun scenario 1 -> passes; start pulsed while busy -> ignored.
